// File: rtl/seq_pkg.sv
// Shared encodings for the fetch/execute sequencer: FSM states,
// instruction type fields, assign-group opcodes and branch conditions.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   // ir[8:7]
   localparam logic [1:0] TYPE_MATH   = 2'b00;
   localparam logic [1:0] TYPE_BRANCH = 2'b01;
   localparam logic [1:0] TYPE_ASSIGN = 2'b10;
   localparam logic [1:0] TYPE_VALUE  = 2'b11;

   // ir[6:4] inside the assign group; 001 and 110 are reserved (nop)
   localparam logic [2:0] OP_LI    = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_CMP   = 3'b100;
   localparam logic [2:0] OP_NOP   = 3'b101;
   localparam logic [2:0] OP_HALT  = 3'b111;

   // ir[6:5] inside the branch group
   localparam logic [1:0] COND_LT = 2'b00;
   localparam logic [1:0] COND_GT = 2'b01;
   localparam logic [1:0] COND_NE = 2'b10;
   localparam logic [1:0] COND_EQ = 2'b11;

   typedef struct packed {
      logic lt;
      logic gt;
      logic eq;
   } flags_t;

endpackage

// File: rtl/instr_sequencer_branch_cond.sv
// Evaluates a branch condition code against the stored compare flags.
module branch_cond
   import seq_pkg::*;
(
   input  logic [1:0] cond,
   input  flags_t     flags,
   output logic       taken
);

   // Select the flag (or its inverse for ne) named by the condition code
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_LT: taken = flags.lt;
         COND_GT: taken = flags.gt;
         COND_NE: taken = ~flags.eq;
         COND_EQ: taken = flags.eq;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute controller: owns PC, IR and compare flags,
// sequences register writeback and the data-memory handshake, and counts
// retired instructions.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int PC_W        = 10,
   parameter int LUT_W       = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       instr_i,
   output logic [PC_W-1:0]  prog_ctr_o,
   output logic [8:0]       ir_o,
   output logic [LUT_W-1:0] lut_idx_o,
   input  logic [PC_W-1:0]  lut_target_i,
   input  logic             alu_lt_i,
   input  logic             alu_gt_i,
   input  logic             alu_eq_i,
   output logic             reg_we_o,
   output logic             flag_we_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_ack_i,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] retired_o
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
   // Last MEM cycle allowed to wait; no ack here means timeout
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [8:0]        ir_q, ir_d;
   flags_t            flags_q, flags_d;
   logic              err_q, err_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              retire;
   logic              taken;
   logic [1:0]        ir_type;
   logic [2:0]        ir_op;
   logic              is_store;
   logic [PC_W-1:0]   pc_inc;

   assign ir_type  = ir_q[8:7];
   assign ir_op    = ir_q[6:4];
   assign is_store = (ir_op == OP_STORE);
   assign pc_inc   = pc_q + 1'b1;

   branch_cond u_branch_cond (
      .cond  (ir_q[6:5]),
      .flags (flags_q),
      .taken (taken)
   );

   assign prog_ctr_o = pc_q;
   assign ir_o       = ir_q;
   assign lut_idx_o  = ir_q[LUT_W-1:0];
   assign err_o      = err_q;
   assign retired_o  = retired_q;

   // Next-state, datapath updates and state-decoded strobes
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      flags_d    = flags_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      retire     = 1'b0;
      reg_we_o   = 1'b0;
      flag_we_o  = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end
         ST_FETCH: begin
            ir_d    = instr_i;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (ir_type)
               TYPE_MATH: state_d = ST_WB;
               TYPE_BRANCH: begin
                  pc_d    = taken ? lut_target_i : pc_inc;
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end
               TYPE_ASSIGN: begin
                  case (ir_op)
                     OP_LI: state_d = ST_WB;
                     OP_LOAD, OP_STORE: begin
                        tmo_d   = '0;
                        state_d = ST_MEM;
                     end
                     OP_CMP: begin
                        flags_d   = '{lt: alu_lt_i, gt: alu_gt_i, eq: alu_eq_i};
                        flag_we_o = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                        retire    = 1'b1;
                     end
                     OP_HALT: begin
                        state_d = ST_HALT;
                        retire  = 1'b1;
                     end
                     default: begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                     end
                  endcase
               end
               default: begin
                  if (ir_q[6]) begin
                     pc_d    = lut_target_i;
                     state_d = ST_FETCH;
                     retire  = 1'b1;
                  end else begin
                     state_d = ST_WB;
                  end
               end
            endcase
         end
         ST_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = is_store;
            if (dmem_ack_i) begin
               if (is_store) begin
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_q == TMO_LAST) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end
            end
         end
         ST_WB: begin
            reg_we_o = 1'b1;
            pc_d     = pc_inc;
            state_d  = ST_FETCH;
            retire   = 1'b1;
         end
         ST_HALT: begin
            done_o = 1'b1;
            if (start) begin
               pc_d    = '0;
               err_d   = 1'b0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      retired_d = (retire && !(&retired_q)) ? retired_q + 1'b1 : retired_q;
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         flags_q   <= '0;
         err_q     <= 1'b0;
         tmo_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of single-instruction vectors
// (each preceded by a cmp that loads the flags) plus hand-written sequences
// for memory waits, timeout, PC wrap, reset during MEM and ignored start.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  instr_i;
   logic [9:0]  prog_ctr_o;
   logic [8:0]  ir_o;
   logic [4:0]  lut_idx_o;
   logic [9:0]  lut_target_i;
   logic        alu_lt = 1'b0, alu_gt = 1'b0, alu_eq = 1'b0;
   logic        reg_we_o, flag_we_o, dmem_req_o, dmem_we_o, dmem_ack_i;
   logic        done_o, err_o;
   logic [15:0] retired_o;

   logic [8:0]  rom [0:1023];
   logic [9:0]  lut [0:31];
   int          ack_wait = 0;
   int          mem_cycles = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   assign instr_i      = rom[prog_ctr_o];
   assign lut_target_i = lut[lut_idx_o];
   assign dmem_ack_i   = dmem_req_o && (ack_wait >= 0) && (mem_cycles == ack_wait);

   // Memory model: counts consecutive request cycles to time the ack
   always @(posedge clk) begin
      if (dmem_req_o) mem_cycles <= mem_cycles + 1;
      else            mem_cycles <= 0;
   end

   instr_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .instr_i      (instr_i),
      .prog_ctr_o   (prog_ctr_o),
      .ir_o         (ir_o),
      .lut_idx_o    (lut_idx_o),
      .lut_target_i (lut_target_i),
      .alu_lt_i     (alu_lt),
      .alu_gt_i     (alu_gt),
      .alu_eq_i     (alu_eq),
      .reg_we_o     (reg_we_o),
      .flag_we_o    (flag_we_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_ack_i   (dmem_ack_i),
      .done_o       (done_o),
      .err_o        (err_o),
      .retired_o    (retired_o)
   );

   typedef struct {
      string      name;
      logic [8:0] instr;
      logic [2:0] flags;
      int         ack;
      int         exp_pc;
      int         exp_cyc;
      int         exp_we;
      int         exp_fwe;
      int         exp_req;
      int         exp_dwe;
      int         exp_done;
   } vec_t;

   vec_t vecs [20];

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clearProgram();
      for (int i = 0; i < 1024; i++) rom[i] = 9'h170;
      for (int i = 0; i < 32; i++) lut[i] = 10'(100 + i);
      lut[0] = 10'd25;
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs until retired_o moves, counting cycles and strobes on the way
   task automatic measure(input string tag, output int n, output int we, output int fwe,
                          output int req, output int dwe);
      logic [15:0] base;
      base = retired_o;
      n = 0; we = 0; fwe = 0; req = 0; dwe = 0;
      while (retired_o == base && n < 60) begin
         n++;
         we  += int'(reg_we_o);
         fwe += int'(flag_we_o);
         req += int'(dmem_req_o);
         dwe += int'(dmem_req_o && dmem_we_o);
         @(negedge clk);
      end
      checkOutput({tag, "_retired"}, int'(retired_o != base), 1);
   endtask

   initial begin
      int n, we, fwe, req, dwe;
      int wemask, donemask;

      vecs[0]  = '{"add",      9'h000, 3'b000, 0,   2, 3, 1, 0, 0, 0, 0};
      vecs[1]  = '{"bl_t",     9'h080, 3'b100, 0,  25, 2, 0, 0, 0, 0, 0};
      vecs[2]  = '{"bl_n",     9'h080, 3'b010, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[3]  = '{"bg_t",     9'h0A0, 3'b010, 0,  25, 2, 0, 0, 0, 0, 0};
      vecs[4]  = '{"bg_n",     9'h0A0, 3'b101, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[5]  = '{"bne_n",    9'h0C0, 3'b001, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[6]  = '{"bne_t",    9'h0C5, 3'b100, 0, 105, 2, 0, 0, 0, 0, 0};
      vecs[7]  = '{"beq_t",    9'h0E0, 3'b001, 0,  25, 2, 0, 0, 0, 0, 0};
      vecs[8]  = '{"beq_n",    9'h0E0, 3'b110, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[9]  = '{"li",       9'h100, 3'b000, 0,   2, 3, 1, 0, 0, 0, 0};
      vecs[10] = '{"mov",      9'h180, 3'b000, 0,   2, 3, 1, 0, 0, 0, 0};
      vecs[11] = '{"jmp",      9'h1C3, 3'b000, 0, 103, 2, 0, 0, 0, 0, 0};
      vecs[12] = '{"nop",      9'h150, 3'b000, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[13] = '{"rsv001",   9'h110, 3'b000, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[14] = '{"rsv110",   9'h160, 3'b000, 0,   2, 2, 0, 0, 0, 0, 0};
      vecs[15] = '{"cmp",      9'h140, 3'b000, 0,   2, 2, 0, 1, 0, 0, 0};
      vecs[16] = '{"halt",     9'h170, 3'b000, 0,   1, 2, 0, 0, 0, 0, 1};
      vecs[17] = '{"load0",    9'h120, 3'b000, 0,   2, 4, 1, 0, 1, 0, 0};
      vecs[18] = '{"store0",   9'h130, 3'b000, 0,   2, 3, 0, 0, 1, 1, 0};
      vecs[19] = '{"store2",   9'h130, 3'b000, 2,   2, 5, 0, 0, 3, 3, 0};

      // Reset state
      clearProgram();
      applyReset();
      checkOutput("rst_pc", int'(prog_ctr_o), 0);
      checkOutput("rst_ir", int'(ir_o), 0);
      checkOutput("rst_strobes", int'({reg_we_o, flag_we_o, dmem_req_o}), 0);
      checkOutput("rst_done", int'(done_o), 0);
      checkOutput("rst_err", int'(err_o), 0);
      checkOutput("rst_retired", int'(retired_o), 0);

      // add then halt, cycle by cycle
      rom[0] = 9'h000;
      rom[1] = 9'h170;
      applyStimulus();
      wemask = 0; donemask = 0;
      for (int c = 0; c < 6; c++) begin
         wemask   |= int'(reg_we_o) << c;
         donemask |= int'(done_o) << c;
         @(negedge clk);
      end
      checkOutput("seqA_we_cycles", wemask, 32'h04);
      checkOutput("seqA_done_cycles", donemask, 32'h20);
      checkOutput("seqA_retired", int'(retired_o), 2);
      checkOutput("seqA_pc", int'(prog_ctr_o), 1);

      // Table: cmp loads flags, then the instruction under test
      for (int v = 0; v < 20; v++) begin
         applyReset();
         clearProgram();
         rom[0] = 9'h140;
         rom[1] = vecs[v].instr;
         {alu_lt, alu_gt, alu_eq} = vecs[v].flags;
         ack_wait = vecs[v].ack;
         applyStimulus();
         measure({vecs[v].name, "_pre"}, n, we, fwe, req, dwe);
         measure(vecs[v].name, n, we, fwe, req, dwe);
         checkOutput({vecs[v].name, "_pc"}, int'(prog_ctr_o), vecs[v].exp_pc);
         checkOutput({vecs[v].name, "_cycles"}, n, vecs[v].exp_cyc);
         checkOutput({vecs[v].name, "_reg_we"}, we, vecs[v].exp_we);
         checkOutput({vecs[v].name, "_flag_we"}, fwe, vecs[v].exp_fwe);
         checkOutput({vecs[v].name, "_req"}, req, vecs[v].exp_req);
         checkOutput({vecs[v].name, "_dmem_we"}, dwe, vecs[v].exp_dwe);
         checkOutput({vecs[v].name, "_done"}, int'(done_o), vecs[v].exp_done);
      end
      {alu_lt, alu_gt, alu_eq} = 3'b000;

      // Load with three wait cycles
      applyReset();
      clearProgram();
      rom[0] = 9'h120;
      ack_wait = 3;
      applyStimulus();
      measure("load3", n, we, fwe, req, dwe);
      checkOutput("load3_cycles", n, 7);
      checkOutput("load3_req", req, 4);
      checkOutput("load3_dmem_we", dwe, 0);
      checkOutput("load3_reg_we", we, 1);
      checkOutput("load3_pc", int'(prog_ctr_o), 1);
      checkOutput("load3_req_after", int'(dmem_req_o), 0);

      // Store never acked: timeout, then restart clears err
      applyReset();
      clearProgram();
      rom[0] = 9'h130;
      ack_wait = -1;
      applyStimulus();
      n = 0; req = 0; dwe = 0;
      while (!done_o && n < 60) begin
         n++;
         req += int'(dmem_req_o);
         dwe += int'(dmem_req_o && dmem_we_o);
         @(negedge clk);
      end
      checkOutput("tmo_cycles", n, 17);
      checkOutput("tmo_req", req, 15);
      checkOutput("tmo_dmem_we", dwe, 15);
      checkOutput("tmo_err", int'(err_o), 1);
      checkOutput("tmo_done", int'(done_o), 1);
      checkOutput("tmo_retired", int'(retired_o), 0);
      checkOutput("tmo_req_halt", int'(dmem_req_o), 0);
      applyStimulus();
      checkOutput("restart_err", int'(err_o), 0);
      checkOutput("restart_done", int'(done_o), 0);
      checkOutput("restart_pc", int'(prog_ctr_o), 0);

      // Ack on the last allowed MEM cycle is a success
      applyReset();
      clearProgram();
      rom[0] = 9'h130;
      ack_wait = 14;
      applyStimulus();
      measure("ack_edge", n, we, fwe, req, dwe);
      checkOutput("ack_edge_cycles", n, 17);
      checkOutput("ack_edge_err", int'(err_o), 0);
      checkOutput("ack_edge_pc", int'(prog_ctr_o), 1);
      checkOutput("ack_edge_done", int'(done_o), 0);

      // jmp to 1023, then jmp from 1023 to 7
      applyReset();
      clearProgram();
      rom[0]    = 9'h1C1;
      lut[1]    = 10'd1023;
      rom[1023] = 9'h1C3;
      lut[3]    = 10'd7;
      applyStimulus();
      measure("jmp_hi", n, we, fwe, req, dwe);
      checkOutput("jmp_hi_pc", int'(prog_ctr_o), 1023);
      measure("jmp_lo", n, we, fwe, req, dwe);
      checkOutput("jmp_lo_pc", int'(prog_ctr_o), 7);

      // nop at 1023 wraps the PC
      applyReset();
      clearProgram();
      rom[0]    = 9'h1C1;
      lut[1]    = 10'd1023;
      rom[1023] = 9'h150;
      applyStimulus();
      measure("wrap_jmp", n, we, fwe, req, dwe);
      measure("wrap_nop", n, we, fwe, req, dwe);
      checkOutput("wrap_pc", int'(prog_ctr_o), 0);

      // Reset asserted while waiting in MEM
      applyReset();
      clearProgram();
      rom[0] = 9'h150;
      rom[1] = 9'h120;
      ack_wait = -1;
      applyStimulus();
      measure("rstmem_nop", n, we, fwe, req, dwe);
      repeat (3) @(negedge clk);
      checkOutput("rstmem_req_before", int'(dmem_req_o), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rstmem_req", int'(dmem_req_o), 0);
      checkOutput("rstmem_pc", int'(prog_ctr_o), 0);
      checkOutput("rstmem_retired", int'(retired_o), 0);
      checkOutput("rstmem_ir", int'(ir_o), 0);
      repeat (3) @(negedge clk);
      checkOutput("rstmem_idle", int'({dmem_req_o, reg_we_o, done_o, prog_ctr_o}), 0);

      // start held through an add is ignored outside IDLE/HALT
      applyReset();
      clearProgram();
      rom[0] = 9'h000;
      ack_wait = 0;
      start = 1'b1;
      @(negedge clk);
      measure("start_exec", n, we, fwe, req, dwe);
      start = 1'b0;
      checkOutput("start_exec_cycles", n, 3);
      checkOutput("start_exec_reg_we", we, 1);
      checkOutput("start_exec_pc", int'(prog_ctr_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 9-bit processor datapath.
- Owns the program counter, instruction register and compare flags.
- Drives the register-file write enable, flag write and the data-memory request/ack handshake.
- Resolves branches through the branch-target LUT, and reports halt, timeout error and retired-instruction count to the top level.

Parameters:
- PC_W, 10, program counter width; the PC wraps modulo 2^PC_W.
- LUT_W, 5, branch-target LUT index width; the index is taken from ir[LUT_W-1:0].
- MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for dmem_ack_i.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begins execution at PC 0 from IDLE or HALT; ignored otherwise
- instr_i  in  9  instruction ROM data at prog_ctr_o (combinational ROM)
- prog_ctr_o  out  PC_W  current PC
- ir_o  out  9  latched instruction, feeds the decoder and datapath
- lut_idx_o  out  LUT_W  ir[LUT_W-1:0]
- lut_target_i  in  PC_W  branch target for lut_idx_o
- alu_lt_i / alu_gt_i / alu_eq_i  in  1 each  ALU compare results for the current ir
- reg_we_o  out  1  register-file write strobe
- flag_we_o  out  1  one-cycle pulse when the flags update
- dmem_req_o  out  1  data-memory request
- dmem_we_o  out  1  1 = store, 0 = load; valid while dmem_req_o=1
- dmem_ack_i  in  1  data-memory completion
- done_o  out  1  high in HALT
- err_o  out  1  sticky memory-timeout error
- retired_o  out  CNT_W  count of retired instructions; saturates at all-ones

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, pc=0, ir=0, flags lt/gt/eq=0, all strobes 0, done_o=0, err_o=0, retired_o=0, timeout counter=0. Reset wins over every other input, mid-operation included; an outstanding memory request is dropped.
- Decode fields:
  - type=ir[8:7].
  - 00: ALU op.
  - 01: branch, cond=ir[6:5]: 00 lt, 01 gt, 10 ne (!eq), 11 eq.
  - 10: op=ir[6:4]: 000 li, 010 load, 011 store, 100 cmp, 101 nop, 111 halt; 001 and 110 are reserved and execute as nop.
  - 11: ir[6]=0 is mov, ir[6]=1 is jmp (unconditional, via LUT).
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE: waits for start, then goes to FETCH with pc=0.
- FETCH (1 cycle): ir <= instr_i, then EXEC.
- EXEC (1 cycle):
  - ALU, li, mov: go to WB.
  - load, store: go to MEM; the timeout counter clears.
  - cmp: flags <= {alu_lt_i, alu_gt_i, alu_eq_i}, flag_we_o=1, pc<=pc+1, then FETCH.
  - branch: if the flag condition is true, pc<=lut_target_i, else pc<=pc+1; then FETCH.
  - jmp: pc<=lut_target_i, then FETCH.
  - nop and reserved ops: pc<=pc+1, then FETCH.
  - halt: pc is held, go to HALT.
- MEM:
  - dmem_req_o=1 and dmem_we_o=store for every MEM cycle.
  - On dmem_ack_i=1: load goes to WB; store does pc<=pc+1 and goes to FETCH.
  - Each cycle without ack increments the counter. When the counter reaches MEM_TIMEOUT without ack, err_o<=1 and go to HALT.
  - Ack in the same cycle as the counter reaching MEM_TIMEOUT counts as success.
  - dmem_req_o deasserts in the cycle after the ack.
- WB (1 cycle): reg_we_o=1, pc<=pc+1, then FETCH.
- Latency per instruction: ALU/li/mov = 3 cycles; cmp, branch, jmp and nop = 2; store = 3 + wait; load = 4 + wait.
- retired_o increments once per completed instruction, halt included, on its final cycle. A timed-out memory op does not retire.
- HALT: done_o=1, strobes 0. start goes to FETCH with pc=0; err_o clears on that start while retired_o is kept.
- Strobe rules: reg_we_o, flag_we_o and dmem_req_o are never asserted outside WB, EXEC (cmp) and MEM respectively.
- PC increment wraps from 2^PC_W-1 to 0.

Decomposition:
- Package seq_pkg holds:
  - state enum (6 states)
  - type encodings (TYPE_MATH/BRANCH/ASSIGN/VALUE)
  - assign-op codes (OP_LI, OP_LOAD, OP_STORE, OP_CMP, OP_NOP, OP_HALT)
  - branch-condition codes
- One sub-module, branch_cond: combinational; inputs cond[1:0] and flags, output taken.

Test Plan:
- Reset then start. ROM: 0=add (9'h000), 1=halt (9'h170). Expect reg_we_o pulse in cycle 3, done_o at cycle 6, retired_o=2, prog_ctr_o=1.
- cmp (9'h140) with alu_lt_i=1, then bl (9'h080) with lut_target_i=25. Expect flag_we_o pulse, then prog_ctr_o=25. Repeat with alu_lt_i=0: expect prog_ctr_o=2.
- Load (9'h120) with ack after 3 wait cycles. Expect dmem_req_o high 4 cycles, dmem_we_o=0, then one reg_we_o pulse, then pc+1.
- Store (9'h130) with no ack. Expect dmem_we_o=1, err_o=1 after 15 wait cycles, done_o=1, retired_o unchanged. A following start clears err_o and restarts at pc=0.
- jmp (9'h1C3) at pc=1023 with lut_target_i=7: expect pc=7. nop at pc=1023: expect pc wraps to 0.
- rst_n=0 asserted during MEM: next cycle dmem_req_o=0, state IDLE, pc=0, retired_o=0. start during EXEC is ignored.
